// File: rtl/prefetch_fetch_unit_pkg.sv
// Shared definitions for the prefetching instruction-fetch stage.
//   OPC_W / OPC_HLT : opcode field width and the halt opcode (opcode sits in
//                     the top OPC_W bits of an instruction word)
//   fetch_state_e   : fetch FSM state encoding
//   is_hlt()        : opcode decode helper
package prefetch_fetch_unit_pkg;

    localparam int               OPC_W   = 4;
    localparam logic [OPC_W-1:0] OPC_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    function automatic logic is_hlt(input logic [OPC_W-1:0] opc);
        return opc == OPC_HLT;
    endfunction

endpackage

// File: rtl/prefetch_fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and the IF/ID stage.
//   imem_req_o / imem_addr_o      : request to instruction memory
//   imem_gnt_i                    : memory accepted the request this cycle
//   imem_rvalid_i / imem_rdata_i  : response (one outstanding at most)
//   id_ready_i                    : IF/ID accepts the head entry
//   inst_valid_o / inst_o / inst_pc_o / inst_npc_o : head entry to IF/ID
// master = fetch stage side, slave = memory / decode side.
interface prefetch_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_gnt_i;
    logic              imem_rvalid_i;
    logic [DATA_W-1:0] imem_rdata_i;
    logic              id_ready_i;
    logic              inst_valid_o;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic [ADDR_W-1:0] inst_npc_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  id_ready_i,
        output inst_valid_o, inst_o, inst_pc_o, inst_npc_o
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output id_ready_i,
        input  inst_valid_o, inst_o, inst_pc_o, inst_npc_o
    );
endinterface

// File: rtl/prefetch_fetch_unit_fifo.sv
// Prefetch queue: DEPTH x W circular buffer with push, pop, flush and count.
//   clk, rst_n : clock, async active-low reset
//   push_i / data_i : write an entry
//   pop_i           : drop the head entry
//   flush_i         : empty the queue (wins over push/pop)
//   data_o / valid_o: head entry and non-empty flag
//   count_o         : occupied entries
// DEPTH must be a power of two so the pointers wrap naturally.
module prefetch_fetch_unit_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [W-1:0]               data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PW'(1);
            if (pop_i)  rd_q <= rd_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset: the top masks the head while the queue is empty.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end

    // The issue rule keeps at most DEPTH entries in flight; a push into a
    // full queue means that rule was broken upstream.
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i)
            assert (!(push_i && !pop_i && count_q == CW'(DEPTH)));
    end

    assign data_o  = mem_q[rd_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Instruction-fetch stage with a prefetch queue. Issues one request at a time
// to variable-latency instruction memory, queues responses for IF/ID, drops
// responses from before a redirect (epoch bit) and stops fetching after HLT.
//   clk, rst_n            : clock, async active-low reset
//   redirect_i/_pc_i      : flush and restart fetch at a new PC
//   bus (master modport)  : imem request/response and IF/ID head entry
//   fetch_pc_o            : next address to request
//   halted_o              : HLT fetched, no more requests until redirect
//   q_count_o             : queued entries
// Build option FETCH_BYPASS_EN: a matching response arriving while the queue
// is empty is presented to IF/ID in the same cycle (and only queued if IF/ID
// stalls). Without it, responses always pass through the queue.
module prefetch_fetch_unit
    import prefetch_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect_i,
    input  logic [ADDR_W-1:0]          redirect_pc_i,
    prefetch_fetch_unit_if.master      bus,
    output logic [ADDR_W-1:0]          fetch_pc_o,
    output logic                       halted_o,
    output logic [$clog2(DEPTH+1)-1:0] q_count_o
);
    localparam int                CW   = $clog2(DEPTH+1);
    localparam int                EW   = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;     // address of the outstanding request
    logic              epoch_q, epoch_d;
    logic              req_epoch_q, req_epoch_d;
    logic              req_q, req_d;

    logic [CW-1:0] count, cnt_nxt;
    logic          fifo_valid;
    logic [EW-1:0] head;

    logic gnt_fire, rsp_ok, rsp_hlt, byp, push, pop;

    assign gnt_fire = req_q && bus.imem_gnt_i;
    assign rsp_ok   = (state_q == ST_WAIT) && bus.imem_rvalid_i && (req_epoch_q == epoch_q);
    assign rsp_hlt  = rsp_ok && is_hlt(bus.imem_rdata_i[DATA_W-1 -: OPC_W]);

`ifdef FETCH_BYPASS_EN
    assign byp = rsp_ok && !redirect_i && (count == '0);
`else
    assign byp = 1'b0;
`endif

    // A bypassed response that IF/ID takes right away never enters the queue.
    assign push    = rsp_ok && !redirect_i && !(byp && bus.id_ready_i);
    assign pop     = fifo_valid && bus.id_ready_i && !redirect_i;
    assign cnt_nxt = redirect_i ? '0 : count + CW'(push) - CW'(pop);

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        epoch_d     = epoch_q;
        req_epoch_d = req_epoch_q;
        req_pc_d    = req_pc_q;
        if (gnt_fire) begin
            req_pc_d    = fetch_pc_q;
            req_epoch_d = epoch_q;
        end
        if (redirect_i) begin
            fetch_pc_d  = redirect_pc_i;
            epoch_d     = ~epoch_q;
            // Whatever is in flight (granted now or earlier) is tagged with the
            // old epoch, so it can never match the new one.
            req_epoch_d = epoch_q;
            state_d     = (gnt_fire || (state_q == ST_WAIT && !bus.imem_rvalid_i))
                          ? ST_WAIT : ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: if (gnt_fire) begin
                    fetch_pc_d = fetch_pc_q + STEP;
                    state_d    = ST_WAIT;
                end
                ST_WAIT: if (bus.imem_rvalid_i) state_d = rsp_hlt ? ST_HALTED : ST_FETCH;
                default: ;
            endcase
        end
        // At most one request is ever outstanding, so "queued + in flight <
        // DEPTH" reduces to a queue check while in FETCH.
        req_d = (state_d == ST_FETCH) && (cnt_nxt < CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            epoch_q     <= 1'b0;
            req_epoch_q <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            epoch_q     <= epoch_d;
            req_epoch_q <= req_epoch_d;
            req_q       <= req_d;
        end
    end

    prefetch_fetch_unit_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  ({bus.imem_rdata_i, req_pc_q}),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .data_o  (head),
        .valid_o (fifo_valid),
        .count_o (count)
    );

    assign bus.imem_req_o   = req_q;
    assign bus.imem_addr_o  = fetch_pc_q;
    assign bus.inst_valid_o = fifo_valid || byp;
    assign bus.inst_o       = byp ? bus.imem_rdata_i
                            : (fifo_valid ? head[EW-1 -: DATA_W] : '0);
    assign bus.inst_pc_o    = byp ? req_pc_q
                            : (fifo_valid ? head[ADDR_W-1:0] : '0);
    assign bus.inst_npc_o   = bus.inst_pc_o + STEP;
    assign fetch_pc_o       = fetch_pc_q;
    assign halted_o         = (state_q == ST_HALTED);
    assign q_count_o        = count;

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Directed bench for prefetch_fetch_unit: DUT A (RESET_PC=0) with a small
// memory model, DUT B (RESET_PC=0xFFFE) driven by hand for wrap and reset.
module tb_prefetch_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_b_n;
    logic        redirect, redirect_b;
    logic [15:0] redirect_pc, redirect_pc_b;
    logic [15:0] fetch_pc_a, fetch_pc_b;
    logic        halted_a, halted_b;
    logic [2:0]  cnt_a, cnt_b;

    prefetch_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) ifa ();
    prefetch_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) ifb ();

    prefetch_fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .PC_STEP(2),
                          .RESET_PC(16'h0000)) u_a (
        .clk(clk), .rst_n(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .bus(ifa), .fetch_pc_o(fetch_pc_a), .halted_o(halted_a), .q_count_o(cnt_a));

    prefetch_fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .PC_STEP(2),
                          .RESET_PC(16'hFFFE)) u_b (
        .clk(clk), .rst_n(rst_b_n), .redirect_i(redirect_b), .redirect_pc_i(redirect_pc_b),
        .bus(ifb), .fetch_pc_o(fetch_pc_b), .halted_o(halted_b), .q_count_o(cnt_b));

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model for DUT A: grant whenever enabled, respond lat+1 cycles later.
    bit          gnt_en;
    int          lat;
    bit          pend;
    int          pend_dly;
    logic [15:0] pend_addr, drv_addr, hlt_addr;
    int          req_seen;
    logic [15:0] got_pc[$], got_inst[$], got_npc[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == hlt_addr) return 16'hF000;
        return {4'h1, a[11:0]};
    endfunction

    task automatic drive();
        ifa.imem_rvalid_i = 1'b0;
        ifa.imem_rdata_i  = 16'h0000;
        if (pend && pend_dly == 0) begin
            ifa.imem_rvalid_i = 1'b1;
            ifa.imem_rdata_i  = mem_word(pend_addr);
        end
        ifa.imem_gnt_i = ifa.imem_req_o && gnt_en;
        drv_addr       = ifa.imem_addr_o;
        if (ifa.imem_req_o) req_seen++;
    endtask

    task automatic capture();
        if (ifa.inst_valid_o && ifa.id_ready_i && !redirect) begin
            got_pc.push_back(ifa.inst_pc_o);
            got_inst.push_back(ifa.inst_o);
            got_npc.push_back(ifa.inst_npc_o);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (ifa.imem_rvalid_i) pend = 1'b0;
        else if (pend) pend_dly--;
        if (ifa.imem_gnt_i) begin
            pend      = 1'b1;
            pend_dly  = lat;
            pend_addr = drv_addr;
        end
        @(negedge clk);
    endtask

    task automatic tick();
        drive();
        #1;
        capture();
        step();
    endtask

    task automatic wait_got(input int n, input int limit);
        for (int k = 0; k < limit && got_pc.size() < n; k++) tick();
    endtask

    int          base;
    logic [15:0] exp_w, exp_pc;

    initial begin
        rst_n = 1'b0; rst_b_n = 1'b0;
        redirect = 1'b0; redirect_pc = '0; redirect_b = 1'b0; redirect_pc_b = '0;
        ifa.imem_gnt_i = 1'b0; ifa.imem_rvalid_i = 1'b0; ifa.imem_rdata_i = '0; ifa.id_ready_i = 1'b1;
        ifb.imem_gnt_i = 1'b0; ifb.imem_rvalid_i = 1'b0; ifb.imem_rdata_i = '0; ifb.id_ready_i = 1'b0;
        gnt_en = 1'b1; lat = 0; pend = 1'b0; pend_dly = 0; pend_addr = '0; drv_addr = '0;
        hlt_addr = 16'h0001; req_seen = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_req",   ifa.imem_req_o,   1'b0);
        chk("rst_valid", ifa.inst_valid_o, 1'b0);
        chk("rst_halt",  halted_a,         1'b0);
        chk("rst_cnt",   cnt_a,            3'd0);
        chk("rst_inst",  ifa.inst_o,       16'h0000);
        chk("rst_pc",    ifa.inst_pc_o,    16'h0000);
        chk("rst_fpc",   fetch_pc_a,       16'h0000);
        rst_n = 1'b1;

        // 1: zero-wait memory, free-flowing decode
        wait_got(3, 40);
        chk("t1_n", got_pc.size(), 3);
        chk("t1_pc0", got_pc[0], 16'h0000); chk("t1_in0", got_inst[0], 16'h1000); chk("t1_np0", got_npc[0], 16'h0002);
        chk("t1_pc1", got_pc[1], 16'h0002); chk("t1_in1", got_inst[1], 16'h1002); chk("t1_np1", got_npc[1], 16'h0004);
        chk("t1_pc2", got_pc[2], 16'h0004); chk("t1_in2", got_inst[2], 16'h1004); chk("t1_np2", got_npc[2], 16'h0006);

        // 2: decode stall fills the queue and throttles requests
        ifa.id_ready_i = 1'b0;
        repeat (10) tick();
        chk("t2_cnt",  cnt_a,            3'd4);
        chk("t2_req",  ifa.imem_req_o,   1'b0);
        chk("t2_head", ifa.inst_pc_o,    16'h0006);
        ifa.id_ready_i = 1'b1;
        wait_got(8, 40);
        chk("t2_n", got_pc.size(), 8);
        chk("t2_pc3", got_pc[3], 16'h0006);
        chk("t2_pc4", got_pc[4], 16'h0008);
        chk("t2_pc5", got_pc[5], 16'h000A);
        chk("t2_pc6", got_pc[6], 16'h000C);
        chk("t2_pc7", got_pc[7], 16'h000E); chk("t2_in7", got_inst[7], 16'h100E);

        // 3: redirect while a slow response is outstanding
        for (int k = 0; k < 20 && !ifa.imem_req_o; k++) tick();
        chk("t3_req", ifa.imem_req_o, 1'b1);
        lat = 2;
        tick();
        lat = 0;
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        base = got_pc.size();
        chk("t3_valid", ifa.inst_valid_o, 1'b0);
        chk("t3_cnt",   cnt_a,            3'd0);
        chk("t3_fpc",   fetch_pc_a,       16'h0100);
        chk("t3_noreq", ifa.imem_req_o,   1'b0);
        wait_got(base + 1, 30);
        chk("t3_n",   got_pc.size(),  base + 1);
        chk("t3_pc",  got_pc[base],   16'h0100);
        chk("t3_in",  got_inst[base], 16'h1100);

        // 4: HLT at 0x0006 stops fetch; redirect resumes
        hlt_addr = 16'h0006;
        redirect = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        base = got_pc.size();
        for (int k = 0; k < 40 && !(halted_a && got_pc.size() >= base + 4); k++) tick();
        chk("t4_n",   got_pc.size(), base + 4);
        chk("t4_pc0", got_pc[base],     16'h0000);
        chk("t4_pc2", got_pc[base + 2], 16'h0004);
        chk("t4_pc3", got_pc[base + 3], 16'h0006);
        chk("t4_hlt", got_inst[base + 3], 16'hF000);
        chk("t4_halted", halted_a, 1'b1);
        req_seen = 0;
        repeat (6) tick();
        chk("t4_noreq", req_seen, 0);
        chk("t4_still", halted_a, 1'b1);
        hlt_addr = 16'h0001;
        redirect = 1'b1; redirect_pc = 16'h0020;
        tick();
        redirect = 1'b0;
        base = got_pc.size();
        chk("t4_unhalt", halted_a,   1'b0);
        chk("t4_fpc",    fetch_pc_a, 16'h0020);
        wait_got(base + 1, 20);
        chk("t4_rpc", got_pc[base],   16'h0020);
        chk("t4_rin", got_inst[base], 16'h1020);

        // 6: response arriving at an empty queue
        for (int k = 0; k < 20 && !(pend && pend_dly == 0 && cnt_a == 3'd0); k++) tick();
        chk("t6_found", {pend, cnt_a}, {1'b1, 3'd0});
        exp_w  = mem_word(pend_addr);
        exp_pc = pend_addr;
        drive();
        #1;
`ifdef FETCH_BYPASS_EN
        chk("t6_byp_valid", ifa.inst_valid_o, 1'b1);
        chk("t6_byp_inst",  ifa.inst_o,       exp_w);
        chk("t6_byp_pc",    ifa.inst_pc_o,    exp_pc);
        capture();
        step();
        chk("t6_byp_cnt", cnt_a, 3'd0);
`else
        chk("t6_lat_valid0", ifa.inst_valid_o, 1'b0);
        capture();
        step();
        chk("t6_lat_cnt",    cnt_a,            3'd1);
        chk("t6_lat_valid1", ifa.inst_valid_o, 1'b1);
        chk("t6_lat_inst",   ifa.inst_o,       exp_w);
        chk("t6_lat_pc",     ifa.inst_pc_o,    exp_pc);
`endif

        // 5: DUT B, PC wrap and reset mid-WAIT
        gnt_en  = 1'b0;
        rst_b_n = 1'b1;
        tick();
        chk("t5_req0",  ifb.imem_req_o,  1'b1);
        chk("t5_addr0", ifb.imem_addr_o, 16'hFFFE);
        ifb.imem_gnt_i = 1'b1;
        tick();
        ifb.imem_gnt_i = 1'b0;
        chk("t5_fpc_wrap", fetch_pc_b, 16'h0000);
        chk("t5_wait_req", ifb.imem_req_o, 1'b0);
        ifb.imem_rvalid_i = 1'b1; ifb.imem_rdata_i = 16'h1234;
        tick();
        ifb.imem_rvalid_i = 1'b0;
        chk("t5_valid", ifb.inst_valid_o, 1'b1);
        chk("t5_inst",  ifb.inst_o,       16'h1234);
        chk("t5_pc",    ifb.inst_pc_o,    16'hFFFE);
        chk("t5_npc",   ifb.inst_npc_o,   16'h0000);
        chk("t5_addr1", ifb.imem_addr_o,  16'h0000);
        chk("t5_req1",  ifb.imem_req_o,   1'b1);
        ifb.imem_gnt_i = 1'b1;
        tick();
        ifb.imem_gnt_i = 1'b0;
        chk("t5_fpc2", fetch_pc_b, 16'h0002);
        rst_b_n = 1'b0;
        #1;
        chk("t5_r_req",   ifb.imem_req_o,   1'b0);
        chk("t5_r_valid", ifb.inst_valid_o, 1'b0);
        chk("t5_r_inst",  ifb.inst_o,       16'h0000);
        chk("t5_r_pc",    ifb.inst_pc_o,    16'h0000);
        chk("t5_r_halt",  halted_b,         1'b0);
        chk("t5_r_cnt",   cnt_b,            3'd0);
        chk("t5_r_fpc",   fetch_pc_b,       16'hFFFE);
        rst_b_n = 1'b1;
        ifb.imem_rvalid_i = 1'b1; ifb.imem_rdata_i = 16'h2222;
        tick();
        ifb.imem_rvalid_i = 1'b0;
        chk("t5_drop_cnt",   cnt_b,            3'd0);
        chk("t5_drop_valid", ifb.inst_valid_o, 1'b0);
        chk("t5_new_req",    ifb.imem_req_o,   1'b1);
        chk("t5_new_addr",   ifb.imem_addr_o,  16'hFFFE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
